// File: rtl/if_id_skid.sv
// IF/ID stage with a 2-entry skid buffer: one cycle latency, 1 beat/cycle, in_ready_o is registered.
// hold_flag_i stalls the stage or flushes it, injecting a NOP bubble at the jump target.
module if_id_skid #(
  parameter int               ADDR_W    = 32,
  parameter int               INST_W    = 32,
  parameter int               HOLD_W    = 3,
  parameter int               STALL_LVL = 1,
  parameter int               FLUSH_LVL = 2,
  parameter logic [INST_W-1:0] NOP_INST = 'h00000001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [HOLD_W-1:0] hold_flag_i,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INST_W-1:0] inst_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              bubble_o,
  output logic [15:0]       flush_cnt_o
);

  localparam logic [HOLD_W-1:0] STALL_L = HOLD_W'(STALL_LVL);
  localparam logic [HOLD_W-1:0] FLUSH_L = HOLD_W'(FLUSH_LVL);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
    logic              bub;
  } beat_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t      state_q, state_d;
  beat_t       out_q, out_d;
  beat_t       skid_q, skid_d;
  beat_t       in_beat;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        flush, stall, take, give;

  assign flush       = hold_flag_i >= FLUSH_L;
  assign stall       = !flush && (hold_flag_i == STALL_L);
  // Ready depends only on registered occupancy and hazard control, never on out_ready_i.
  assign in_ready_o  = !rst && (state_q != FULL) && !stall && !flush;
  assign out_valid_o = state_q != EMPTY;
  assign take        = in_valid_i && in_ready_o;
  assign give        = out_valid_o && out_ready_i && !stall;
  assign in_beat     = '{addr: inst_addr_i, inst: inst_i, bub: 1'b0};

  assign inst_addr_o = out_q.addr;
  assign inst_o      = out_q.inst;
  assign bubble_o    = out_q.bub;
  assign flush_cnt_o = flush_cnt_q;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    skid_d      = skid_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      out_d   = '{addr: jump_addr_i, inst: NOP_INST, bub: 1'b1};
      state_d = ONE;
      if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end else if (!stall) begin
      case (state_q)
        EMPTY: begin
          if (take) begin
            out_d   = in_beat;
            state_d = ONE;
          end
        end
        ONE: begin
          if (take && give) begin
            out_d = in_beat;
          end else if (give) begin
            state_d = EMPTY;
          end else if (take) begin
            skid_d  = in_beat;
            state_d = FULL;
          end
        end
        FULL: begin
          if (give) begin
            out_d   = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid.sv
// Scoreboard bench for if_id_skid: the driver queues expected beats, a negedge monitor checks deliveries.
`timescale 1ns/1ps
module tb_if_id_skid;

  logic        clk, rst;
  logic [31:0] inst_addr_i, inst_i, jump_addr_i;
  logic        in_valid_i, in_ready_o, out_ready_i, out_valid_o, bubble_o;
  logic [2:0]  hold_flag_i;
  logic [31:0] inst_addr_o, inst_o;
  logic [15:0] flush_cnt_o;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] i;
    logic        b;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  if_id_skid dut (
    .clk(clk), .rst(rst),
    .inst_addr_i(inst_addr_i), .inst_i(inst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .jump_addr_i(jump_addr_i), .hold_flag_i(hold_flag_i),
    .inst_addr_o(inst_addr_o), .inst_o(inst_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .bubble_o(bubble_o), .flush_cnt_o(flush_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // One clock of stimulus; the expected response is queued at the negedge where the DUT decides.
  task automatic cycle(input logic r, input logic v, input logic [31:0] a, input logic [31:0] ins,
                       input logic rdy, input logic [2:0] h, input logic [31:0] j);
    rst = r; in_valid_i = v; inst_addr_i = a; inst_i = ins;
    out_ready_i = rdy; hold_flag_i = h; jump_addr_i = j;
    @(negedge clk);
    if (r) begin
      exp_q.delete();
    end else if (h >= 3'd2) begin
      exp_q.delete();
      exp_q.push_back('{a: j, i: 32'h00000001, b: 1'b1});
    end else if (v && in_ready_o) begin
      exp_q.push_back('{a: a, i: ins, b: 1'b0});
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i && hold_flag_i != 3'd1 && hold_flag_i < 3'd2) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got addr %h inst %h, required no beat", inst_addr_o, inst_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("beat", {inst_addr_o, inst_o, bubble_o}, {e.a, e.i, e.b});
      end
    end
  end

  initial begin
    #2_000_000;
    tests++;
    fails++;
    $display("FAIL timeout: got no end of run, required finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("rst_out_valid", 65'(out_valid_o), 65'd0);
    chk("rst_addr_inst_bub", {inst_addr_o, inst_o, bubble_o}, 65'd0);
    chk("rst_flush_cnt", 65'(flush_cnt_o), 65'd0);
    chk("rst_in_ready", 65'(in_ready_o), 65'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 65'(in_ready_o), 65'd1);

    // Streaming, one beat per cycle
    for (int n = 0; n < 8; n++) begin
      cycle(0, 1, 32'(4 * n), 32'(32'hA0 + n), 1, 0, 0);
      if (n == 0) chk("first_latency", {31'd0, out_valid_o, inst_addr_o, inst_o}, {31'd0, 1'b1, 32'h0, 32'hA0});
    end
    cycle(0, 0, 0, 0, 1, 0, 0);
    chk("stream_drained", 65'(exp_q.size()), 65'd0);

    // Backpressure: skid absorbs one beat, ready drops
    cycle(0, 1, 32'h0, 32'hB0, 0, 0, 0);
    cycle(0, 1, 32'h4, 32'hB1, 0, 0, 0);
    chk("bp_in_ready", 65'(in_ready_o), 65'd0);
    chk("bp_out_head", {32'd0, out_valid_o, inst_addr_o}, {32'd0, 1'b1, 32'h0});
    cycle(0, 1, 32'h8, 32'hB2, 0, 0, 0);
    for (int n = 0; n < 3; n++) cycle(0, 0, 0, 0, 1, 0, 0);
    chk("bp_drained", 65'(exp_q.size()), 65'd0);

    // Flush while FULL
    cycle(0, 1, 32'h10, 32'hD0, 0, 0, 0);
    cycle(0, 1, 32'h14, 32'hD1, 0, 0, 0);
    cycle(0, 1, 32'h18, 32'hD2, 0, 2, 32'h200);
    chk("flush_out", {inst_addr_o, inst_o, bubble_o}, {32'h200, 32'h00000001, 1'b1});
    chk("flush_valid", 65'(out_valid_o), 65'd1);
    chk("flush_cnt", 65'(flush_cnt_o), 65'd1);
    hold_flag_i = 3'd0;
    in_valid_i  = 1'b0;
    #1;
    chk("flush_skid_empty", 65'(in_ready_o), 65'd1);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    chk("flush_drained", 65'(exp_q.size()), 65'd0);

    // Stall during streaming
    for (int n = 0; n < 3; n++) cycle(0, 1, 32'(32'h300 + 4 * n), 32'(32'hC0 + n), 1, 0, 0);
    for (int n = 0; n < 3; n++) begin
      cycle(0, 1, 32'h30C, 32'hC3, 1, 1, 0);
      chk("stall_in_ready", 65'(in_ready_o), 65'd0);
      chk("stall_frozen", {32'd0, out_valid_o, inst_addr_o}, {32'd0, 1'b1, 32'h308});
    end
    cycle(0, 1, 32'h30C, 32'hC3, 1, 0, 0);
    cycle(0, 1, 32'h310, 32'hC4, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    chk("stall_drained", 65'(exp_q.size()), 65'd0);

    // Reset while FULL discards both beats
    cycle(0, 1, 32'h400, 32'hE0, 0, 0, 0);
    cycle(0, 1, 32'h404, 32'hE1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("midrst_valid", 65'(out_valid_o), 65'd0);
    chk("midrst_cnt", 65'(flush_cnt_o), 65'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 65'(in_ready_o), 65'd1);
    for (int n = 0; n < 3; n++) cycle(0, 0, 0, 0, 1, 0, 0);

    // Flush counter saturation; each flush reloads with the latest jump address
    for (int k = 1; k <= 65540; k++) begin
      cycle(0, 0, 0, 0, 0, 2, 32'(k));
      if (k == 65534) chk("cnt_before_sat", 65'(flush_cnt_o), 65'h0FFFE);
    end
    chk("cnt_saturated", 65'(flush_cnt_o), 65'h0FFFF);
    chk("latest_jump", 65'(inst_addr_o), 65'd65540);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    chk("final_drained", 65'(exp_q.size()), 65'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
